// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - instruction fetch unit: PC, memory request, fetch queue, redirect and fault handling
module instruction_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          DEPTH     = 4,
    parameter int          MEM_BYTES = 262144
) (
    input  logic        clock,
    input  logic        reset0,
    input  logic        start,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_data,
    output logic        mem_write_enable,
    input  logic [31:0] mem_outp,
    input  logic        mem_valid,
    output logic [31:0] inst_out,
    output logic [31:0] pc_out,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic        fault,
    output logic [31:0] fault_pc,
    output logic        busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [31:0]   LAST_PC = 32'(MEM_BYTES - 4);
    localparam logic [CW-1:0] FULL    = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [31:0]     pc;
    logic [31:0]     pc_next;
    logic [CW-1:0]   count;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [31:0]     inst_q [DEPTH];
    logic [31:0]     pc_q   [DEPTH];
    logic            push;
    logic            pop;
    logic            fault_set;
    logic            flush;

    // Redirect overrides everything: no push, no pop, no fault check that cycle.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        push       = 1'b0;
        pop        = 1'b0;
        fault_set  = 1'b0;
        flush      = 1'b0;
        if (redirect) begin
            flush      = 1'b1;
            pc_next    = redirect_pc;
            state_next = FETCH;
        end else begin
            pop = (count != '0) && inst_ready;
            case (state)
                IDLE: begin
                    if (start) begin
                        state_next = FETCH;
                    end
                end
                FETCH: begin
                    // A full queue suppresses the fetch entirely, so no fault can be raised either.
                    if (count != FULL) begin
                        if (mem_valid && (pc <= LAST_PC)) begin
                            push    = 1'b1;
                            pc_next = pc + 32'd4;
                        end else begin
                            fault_set  = 1'b1;
                            state_next = FAULT;
                        end
                    end
                end
                FAULT: begin
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset0) begin
        if (reset0) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clock or posedge reset0) begin
        if (reset0) begin
            pc       <= RESET_PC;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fault    <= 1'b0;
            fault_pc <= 32'h0;
        end else begin
            pc <= pc_next;
            if (flush) begin
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
                fault  <= 1'b0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                case ({push, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
                if (fault_set) begin
                    fault    <= 1'b1;
                    fault_pc <= pc;
                end
            end
        end
    end

    // Queue storage carries no reset; the output mux hides stale entries.
    always_ff @(posedge clock) begin
        if (push) begin
            inst_q[wr_ptr] <= mem_outp;
            pc_q[wr_ptr]   <= pc;
        end
    end

    assign inst_valid       = (count != '0);
    assign inst_out         = inst_valid ? inst_q[rd_ptr] : 32'h0;
    assign pc_out           = inst_valid ? pc_q[rd_ptr] : 32'h0;
    assign busy             = (state == FETCH);
    assign mem_addr         = pc;
    assign mem_data         = 32'h0;
    assign mem_write_enable = 1'b0;

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - self-checking bench for instruction_fetch against a queue-level model
module tb_instruction_fetch;

    localparam int          DEPTH   = 4;
    localparam logic [31:0] LAST_PC = 32'h0003_FFFC;

    logic        clock;
    logic        reset0;
    logic        start;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        mem_write_enable;
    logic [31:0] mem_outp;
    logic        mem_valid;
    logic [31:0] inst_out;
    logic [31:0] pc_out;
    logic        inst_valid;
    logic        inst_ready;
    logic        fault;
    logic [31:0] fault_pc;
    logic        busy;

    int errors = 0;
    int checks = 0;

    instruction_fetch dut (
        .clock            (clock),
        .reset0           (reset0),
        .start            (start),
        .redirect         (redirect),
        .redirect_pc      (redirect_pc),
        .mem_addr         (mem_addr),
        .mem_data         (mem_data),
        .mem_write_enable (mem_write_enable),
        .mem_outp         (mem_outp),
        .mem_valid        (mem_valid),
        .inst_out         (inst_out),
        .pc_out           (pc_out),
        .inst_valid       (inst_valid),
        .inst_ready       (inst_ready),
        .fault            (fault),
        .fault_pc         (fault_pc),
        .busy             (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Combinational instruction memory: word = address + 0x100, valid only when aligned.
    assign mem_outp  = mem_addr + 32'h100;
    assign mem_valid = (mem_addr[1:0] == 2'b00);

    // Model: queue of {pc, inst}, a fetch pointer and a mode (0 idle, 1 fetching, 2 faulted).
    logic [63:0] mq[$];
    logic [31:0] m_pc       = 32'h0;
    logic [31:0] m_fault_pc = 32'h0;
    bit          m_fault    = 1'b0;
    int          m_mode     = 0;

    task automatic model_reset();
        mq.delete();
        m_pc       = 32'h0;
        m_fault    = 1'b0;
        m_fault_pc = 32'h0;
        m_mode     = 0;
    endtask

    task automatic model_step();
        bit do_pop;
        bit issue;
        if (redirect) begin
            mq.delete();
            m_pc    = redirect_pc;
            m_fault = 1'b0;
            m_mode  = 1;
        end else begin
            do_pop = (mq.size() > 0) && inst_ready;
            issue  = (m_mode == 1) && (mq.size() < DEPTH);
            if (m_mode == 0 && start) m_mode = 1;
            if (do_pop) void'(mq.pop_front());
            if (issue) begin
                if (m_pc[1:0] == 2'b00 && m_pc <= LAST_PC) begin
                    mq.push_back({m_pc, m_pc + 32'h100});
                    m_pc = m_pc + 32'd4;
                end else begin
                    m_fault    = 1'b1;
                    m_fault_pc = m_pc;
                    m_mode     = 2;
                end
            end
        end
    endtask

    always @(posedge clock) begin
        if (reset0) model_reset();
        else model_step();
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        check("inst_valid", 32'(inst_valid), 32'(mq.size() > 0));
        if (mq.size() > 0) begin
            check("pc_out", pc_out, mq[0][63:32]);
            check("inst_out", inst_out, mq[0][31:0]);
        end
        check("mem_addr", mem_addr, m_pc);
        check("busy", 32'(busy), 32'(m_mode == 1));
        check("fault", 32'(fault), 32'(m_fault));
        check("fault_pc", fault_pc, m_fault_pc);
        check("mem_write_enable", 32'(mem_write_enable), 32'h0);
        check("mem_data", mem_data, 32'h0);
    end

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset0   = 1'b1;
        start    = 1'b0;
        redirect = 1'b0;
        tick();
        reset0 = 1'b0;
    endtask

    initial begin
        reset0      = 1'b1;
        start       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        inst_ready  = 1'b0;
        tick();
        tick();
        check("t0 reset inst_valid", 32'(inst_valid), 32'h0);
        check("t0 reset busy", 32'(busy), 32'h0);
        check("t0 reset mem_addr", mem_addr, 32'h0);
        check("t0 reset fault", 32'(fault), 32'h0);
        reset0 = 1'b0;
        tick();

        // Streaming with decode always ready
        inst_ready = 1'b1;
        start      = 1'b1;
        tick();
        start = 1'b0;
        check("t1 busy after start", 32'(busy), 32'h1);
        check("t1 no valid yet", 32'(inst_valid), 32'h0);
        tick();
        check("t1 first valid", 32'(inst_valid), 32'h1);
        check("t1 first pc", pc_out, 32'h0);
        check("t1 first inst", inst_out, 32'h100);
        for (int k = 1; k <= 5; k++) begin
            tick();
            check("t1 stream pc", pc_out, 32'(4 * k));
        end

        // Back-pressure fills the queue, one pop then refill
        do_reset();
        inst_ready = 1'b0;
        start      = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        check("t2 full mem_addr", mem_addr, 32'h10);
        check("t2 full head pc", pc_out, 32'h0);
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        check("t2 after pop pc", pc_out, 32'h4);
        check("t2 no fetch on full", mem_addr, 32'h10);
        tick();
        check("t2 refill mem_addr", mem_addr, 32'h14);

        // Redirect flush with coincident pop
        do_reset();
        inst_ready = 1'b0;
        start      = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        check("t3 head before redirect", pc_out, 32'h0);
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        inst_ready  = 1'b1;
        start       = 1'b1;
        tick();
        redirect = 1'b0;
        start    = 1'b0;
        check("t3 flushed", 32'(inst_valid), 32'h0);
        check("t3 new mem_addr", mem_addr, 32'h40);
        tick();
        check("t3 redirected pc", pc_out, 32'h40);

        // Misaligned redirect faults, redirect recovers
        redirect    = 1'b1;
        redirect_pc = 32'h42;
        tick();
        redirect = 1'b0;
        check("t4 no fault yet", 32'(fault), 32'h0);
        tick();
        check("t4 fault", 32'(fault), 32'h1);
        check("t4 fault_pc", fault_pc, 32'h42);
        check("t4 not busy", 32'(busy), 32'h0);
        repeat (2) tick();
        check("t4 no pushes", 32'(inst_valid), 32'h0);
        redirect    = 1'b1;
        redirect_pc = 32'h80;
        tick();
        redirect = 1'b0;
        check("t4 fault cleared", 32'(fault), 32'h0);
        check("t4 resume addr", mem_addr, 32'h80);
        tick();
        check("t4 resume pc", pc_out, 32'h80);
        check("t4 resume inst", inst_out, 32'h180);

        // Last in-range word, then out-of-range fault
        redirect    = 1'b1;
        redirect_pc = 32'h3FFFC;
        inst_ready  = 1'b0;
        tick();
        redirect = 1'b0;
        tick();
        check("t5 last word pc", pc_out, 32'h3FFFC);
        check("t5 last word inst", inst_out, 32'h400FC);
        check("t5 next addr", mem_addr, 32'h40000);
        tick();
        check("t5 range fault", 32'(fault), 32'h1);
        check("t5 range fault_pc", fault_pc, 32'h40000);
        check("t5 old entry kept", 32'(inst_valid), 32'h1);

        // Asynchronous reset mid-cycle with three queued entries
        redirect    = 1'b1;
        redirect_pc = 32'h0;
        tick();
        redirect = 1'b0;
        repeat (3) tick();
        check("t6 three queued addr", mem_addr, 32'hC);
        #2;
        reset0 = 1'b1;
        model_reset();
        #1;
        check("t6 async inst_valid", 32'(inst_valid), 32'h0);
        check("t6 async busy", 32'(busy), 32'h0);
        check("t6 async mem_addr", mem_addr, 32'h0);
        check("t6 async fault", 32'(fault), 32'h0);
        check("t6 async fault_pc", fault_pc, 32'h0);
        check("t6 async pc_out", pc_out, 32'h0);
        check("t6 async inst_out", inst_out, 32'h0);
        check("t6 async mem_we", 32'(mem_write_enable), 32'h0);
        tick();
        reset0 = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Initiator side of the instruction-memory interface.
- Holds the program counter and drives the word address to instruction memory.
- Samples the returned word and its valid flag, and queues {pc, instruction} pairs in a small FIFO for decode.
- Handles branch redirects (flush plus new PC), misaligned or out-of-range fetch faults, and decode back-pressure.

Parameters:
- RESET_PC, 32'h0000_0000: PC loaded on reset; also the boot address.
- DEPTH, 4: fetch-queue entries; power of 2, at least 2.
- MEM_BYTES, 262144: instruction-memory size in bytes; a fetch at pc > MEM_BYTES-4 faults.

Ports:
- clock  in  1  system clock, rising edge
- reset0  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; leaves IDLE and begins fetching
- redirect  in  1  branch/jump taken; flush queue and load redirect_pc
- redirect_pc  in  32  new fetch address
- mem_addr  out  32  byte address to instruction memory (= pc register)
- mem_data  out  32  write data to memory; tied 0
- mem_write_enable  out  1  tied 0; this block never writes
- mem_outp  in  32  instruction word returned combinationally for mem_addr
- mem_valid  in  1  1 = mem_addr word-aligned and read data good
- inst_out  out  32  instruction at queue head
- pc_out  out  32  PC of the queue-head instruction
- inst_valid  out  1  queue non-empty
- inst_ready  in  1  decode accepts head this cycle
- fault  out  1  sticky fetch fault
- fault_pc  out  32  PC that faulted
- busy  out  1  1 when state is FETCH

Behaviour:
- States: IDLE, FETCH, FAULT; state register is 2 bits.
- Reset (reset0=1, asynchronous, any time):
  - state=IDLE, pc=RESET_PC, queue count=0, read/write pointers=0.
  - fault=0, fault_pc=0; outputs follow: inst_valid=0, busy=0, mem_addr=RESET_PC.
  - inst_out/pc_out are don't-care while inst_valid=0; drive 0 after reset.
- IDLE:
  - No pushes.
  - start=1 -> FETCH at the next edge; first push happens the cycle after.
  - redirect in IDLE: pc<=redirect_pc, state -> FETCH.
- FETCH, per cycle:
  - mem_addr=pc.
  - If count<DEPTH, the fetch is issued and mem_outp/mem_valid are sampled at the same rising edge (memory is combinational, so latency is 0 cycles addr->data and 1 cycle fetch->inst_valid).
  - mem_valid=1 and pc <= MEM_BYTES-4: push {pc, mem_outp}; pc<=pc+4, modulo 2^32.
  - mem_valid=0 or pc > MEM_BYTES-4: no push, pc holds, fault<=1, fault_pc<=pc, state -> FAULT.
  - count==DEPTH: no fetch and no fault check, even if a pop happens the same cycle. There is no full-bypass, so peak throughput is sustained only while count<DEPTH.
- FAULT:
  - No fetches.
  - The queue keeps draining to decode; entries older than the fault stay valid.
  - Exits only on redirect or reset.
- Pop: when inst_valid && inst_ready, the head is removed at the edge.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Redirect (any state, highest priority):
  - At the edge: queue flushed (count=0, pointers=0), pc<=redirect_pc, fault<=0, state -> FETCH.
  - No push and no pop that cycle; a pop handshake in the same cycle is discarded.
  - A misaligned redirect_pc faults on the following cycle via mem_valid=0.
- start while not in IDLE: ignored.
- Pointers wrap modulo DEPTH; count ranges 0..DEPTH.
- inst_out/pc_out are driven from the head entry (registered storage, no combinational path from mem_outp).
- mem_write_enable and mem_data are constant 0 in every state, including reset.

Test Plan:
1. Reset, start pulse, memory returns word=addr+32'h100, inst_ready=1 continuously -> first inst_valid 2 cycles after start, with pc_out=0, inst_out=32'h100; then pc_out 4, 8, 12… every cycle with no gaps.
2. inst_ready=0 after start -> exactly 4 pushes (pc 0..12); mem_addr holds 16 and count stays 4. Raise inst_ready for one cycle -> pc 0 popped, refill at next fetch, pc_out=4.
3. Queue holds pc 0..8, redirect=1 with redirect_pc=32'h40 and inst_ready=1 the same cycle -> next cycle inst_valid=0, mem_addr=32'h40; the following cycle pc_out=32'h40.
4. redirect_pc=32'h42 (memory drives mem_valid=0) -> fault=1, fault_pc=32'h42, state FAULT, no pushes; then redirect to 32'h80 -> fault=0 and fetching resumes at 32'h80.
5. Redirect to MEM_BYTES-4 (32'h3FFFC) -> one push with pc_out=32'h3FFFC; the next fetch at 32'h40000 faults with fault_pc=32'h40000.
6. Assert reset0 asynchronously mid-fetch with queue count=3 -> all outputs return to reset values immediately, without waiting for a clock edge; mem_write_enable stays 0 throughout every test.
